// File: rtl/timer_seq_pkg.sv
// Shared types and timer register map for timer_cfg_sequencer.
package timer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WR_STOP,
    WR_PL,
    WR_PH,
    WR_STAT,
    WR_CTRL,
    DONE
  } state_t;

  localparam int TMR_ADDR_STATUS  = 0;
  localparam int TMR_ADDR_CONTROL = 1;
  localparam int TMR_ADDR_PERIODL = 2;
  localparam int TMR_ADDR_PERIODH = 3;

  localparam int TMR_CTRL_ITO   = 0;
  localparam int TMR_CTRL_CONT  = 1;
  localparam int TMR_CTRL_START = 2;
  localparam int TMR_CTRL_STOP  = 3;

  function automatic logic [15:0] ctrl_start_word(input logic cont, input logic irq_en);
    logic [15:0] w;
    w = '0;
    w[TMR_CTRL_START] = 1'b1;
    w[TMR_CTRL_CONT]  = cont;
    w[TMR_CTRL_ITO]   = irq_en;
    return w;
  endfunction

  function automatic logic [15:0] ctrl_stop_word();
    logic [15:0] w;
    w = '0;
    w[TMR_CTRL_STOP] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/timer_cfg_sequencer_if.sv
// Avalon-MM write-only master bus toward the interval timer's s1 slave.
interface timer_cfg_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] av_address;
  logic              av_chipselect;
  logic              av_write_n;
  logic [DATA_W-1:0] av_writedata;

  modport master (
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata
  );

  modport slave (
    input av_address,
    input av_chipselect,
    input av_write_n,
    input av_writedata
  );
endinterface

// File: rtl/timer_cfg_sequencer_rr_arbiter.sv
// Combinational round-robin picker: first set req bit after the last owner, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  int               idx;
  logic [IDX_W-1:0] idx_b;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    idx_b   = '0;
    // k runs 1..NUM_REQ so the last owner is considered only after everyone else
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(last) + k) % NUM_REQ;
      idx_b = IDX_W'(idx);
      if (!found && req[idx_b]) begin
        found      = 1'b1;
        gnt[idx_b] = 1'b1;
        gnt_idx    = idx_b;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/timer_cfg_sequencer.sv
// Arbitrates requesters and programs the interval timer with a fixed write sequence.
// Optional macro TIMER_SEQ_STOP_FIRST_EN inserts a CONTROL.STOP write before the period writes.
module timer_cfg_sequencer
  import timer_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*32-1:0]  req_period,
  input  logic [NUM_REQ-1:0]     req_cont,
  input  logic [NUM_REQ-1:0]     req_irq_en,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner,
  timer_cfg_sequencer_if.master  av
);

  state_t state, state_nxt;

  logic [31:0]        period_q;
  logic               cont_q;
  logic               irq_en_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [31:0]        sel_period;
  logic               sel_cont;
  logic               sel_irq_en;

  logic               cs_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic [NUM_REQ-1:0] ack_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req),
    .last    (owner),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    sel_period = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_period = req_period[i*32 +: 32];
    end
  end

  assign sel_cont   = |(req_cont & gnt);
  assign sel_irq_en = |(req_irq_en & gnt);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = GRANT;
`ifdef TIMER_SEQ_STOP_FIRST_EN
      GRANT:   state_nxt = WR_STOP;
      WR_STOP: state_nxt = WR_PL;
`else
      GRANT:   state_nxt = WR_PL;
`endif
      WR_PL:   state_nxt = WR_PH;
      WR_PH:   state_nxt = WR_STAT;
      WR_STAT: state_nxt = WR_CTRL;
      WR_CTRL: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus and ack outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    cs_nxt   = 1'b0;
    addr_nxt = '0;
    data_nxt = '0;
    ack_nxt  = '0;
    case (state_nxt)
`ifdef TIMER_SEQ_STOP_FIRST_EN
      WR_STOP: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_W'(TMR_ADDR_CONTROL);
        data_nxt = DATA_W'(ctrl_stop_word());
      end
`endif
      WR_PL: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_W'(TMR_ADDR_PERIODL);
        data_nxt = DATA_W'(period_q[15:0]);
      end
      WR_PH: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_W'(TMR_ADDR_PERIODH);
        data_nxt = DATA_W'(period_q[31:16]);
      end
      WR_STAT: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_W'(TMR_ADDR_STATUS);
        data_nxt = '0;
      end
      WR_CTRL: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_W'(TMR_ADDR_CONTROL);
        data_nxt = DATA_W'(ctrl_start_word(cont_q, irq_en_q));
      end
      DONE:    ack_nxt[owner] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      owner            <= IDX_W'(NUM_REQ - 1);
      period_q         <= '0;
      cont_q           <= 1'b0;
      irq_en_q         <= 1'b0;
      ack              <= '0;
      av.av_chipselect <= 1'b0;
      av.av_write_n    <= 1'b1;
      av.av_address    <= '0;
      av.av_writedata  <= '0;
    end else begin
      state            <= state_nxt;
      ack              <= ack_nxt;
      av.av_chipselect <= cs_nxt;
      av.av_write_n    <= ~cs_nxt;
      av.av_address    <= addr_nxt;
      av.av_writedata  <= data_nxt;
      if (state == IDLE && gnt_any) begin
        owner    <= gnt_idx;
        period_q <= sel_period;
        cont_q   <= sel_cont;
        irq_en_q <= sel_irq_en;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Directed and randomized checks of timer_cfg_sequencer against a transaction-level model.
module tb_timer_cfg_sequencer;

  localparam int N  = 3;
  localparam int IW = 2;
`ifdef TIMER_SEQ_STOP_FIRST_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int ACK_LAT = 6 + EXTRA;
  localparam int SPACING = 7 + EXTRA;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*32-1:0] req_period;
  logic [N-1:0]    req_cont;
  logic [N-1:0]    req_irq_en;
  logic [N-1:0]    ack;
  logic            busy;
  logic [IW-1:0]   owner;

  timer_cfg_sequencer_if #(.ADDR_W(3), .DATA_W(16)) av ();

  timer_cfg_sequencer #(.NUM_REQ(N), .DATA_W(16), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_period (req_period),
    .req_cont   (req_cont),
    .req_irq_en (req_irq_en),
    .ack        (ack),
    .busy       (busy),
    .owner      (owner),
    .av         (av.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed bus writes {cycle, addr, data} and acks {cycle, ack}
  logic [50:0] wr_q[$];
  logic [50:0] exp_wr_q[$];
  logic [34:0] ack_q[$];
  logic [34:0] exp_ack_q[$];

  always @(negedge clk) begin
    if (av.av_chipselect === 1'b1 && av.av_write_n === 1'b0)
      wr_q.push_back({32'(cyc), av.av_address, av.av_writedata});
    if (ack !== '0 && ack !== 'x)
      ack_q.push_back({32'(cyc), ack});
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model state: who was granted last
  int m_owner;

  function automatic int rr_next(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) begin
      if (pend[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // One full programming transaction sampled at cycle s
  task automatic exp_seq(input int s, input int who, input logic [31:0] p,
                         input logic c, input logic ie);
    int t;
    logic [15:0] cw;
    t  = s + 2;
`ifdef TIMER_SEQ_STOP_FIRST_EN
    exp_wr_q.push_back({32'(t), 3'd1, 16'h0008});
    t++;
`endif
    cw = 16'h0004 | {14'd0, c, ie};
    exp_wr_q.push_back({32'(t),     3'd2, p[15:0]});
    exp_wr_q.push_back({32'(t + 1), 3'd3, p[31:16]});
    exp_wr_q.push_back({32'(t + 2), 3'd0, 16'h0000});
    exp_wr_q.push_back({32'(t + 3), 3'd1, cw});
    exp_ack_q.push_back({32'(s + ACK_LAT), N'(1) << who});
    m_owner = who;
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, " wr_count"}, 64'(wr_q.size()), 64'(exp_wr_q.size()));
    n = (wr_q.size() < exp_wr_q.size()) ? wr_q.size() : exp_wr_q.size();
    for (int i = 0; i < n; i++) check({tag, " wr"}, 64'(wr_q[i]), 64'(exp_wr_q[i]));
    check({tag, " ack_count"}, 64'(ack_q.size()), 64'(exp_ack_q.size()));
    n = (ack_q.size() < exp_ack_q.size()) ? ack_q.size() : exp_ack_q.size();
    for (int i = 0; i < n; i++) check({tag, " ack"}, 64'(ack_q[i]), 64'(exp_ack_q[i]));
    wr_q.delete(); exp_wr_q.delete(); ack_q.delete(); exp_ack_q.delete();
  endtask

  // Grant schedule predicted from how many sequences each requester wants
  int          want[N];
  int          sch_s[$];
  int          sch_who[$];
  logic [31:0] sch_newp[$];
  bit          sch_last[$];

  task automatic plan(input bit scramble);
    int          s;
    int          cnt[N];
    logic [31:0] mp[N];
    logic [N-1:0] pend;
    logic [31:0] np;
    int          who;
    sch_s.delete(); sch_who.delete(); sch_newp.delete(); sch_last.delete();
    s = cyc;
    for (int i = 0; i < N; i++) begin
      cnt[i] = want[i];
      mp[i]  = req_period[i*32 +: 32];
      req[i] = (want[i] > 0);
    end
    for (int g = 0; g < 32; g++) begin
      for (int i = 0; i < N; i++) pend[i] = (cnt[i] > 0);
      if (pend == '0) break;
      who = rr_next(pend, m_owner);
      exp_seq(s, who, mp[who], req_cont[who], req_irq_en[who]);
      cnt[who]--;
      np = scramble ? $urandom : mp[who];
      sch_s.push_back(s);
      sch_who.push_back(who);
      sch_last.push_back(cnt[who] == 0);
      sch_newp.push_back(np);
      mp[who] = np;
      s += SPACING;
    end
  endtask

  task automatic run_plan(input string tag);
    int t_end;
    t_end = sch_s[sch_s.size() - 1] + ACK_LAT + 2;
    while (cyc < t_end) begin
      step(1);
      for (int k = 0; k < sch_s.size(); k++) begin
        if (cyc == sch_s[k] + 1) begin
          check({tag, " owner"}, 64'(owner), 64'(sch_who[k]));
          req_period[sch_who[k]*32 +: 32] = sch_newp[k];
        end
        if (cyc == sch_s[k] + ACK_LAT && sch_last[k]) req[sch_who[k]] = 1'b0;
      end
    end
    compare(tag);
  endtask

  initial begin
    int t0, s2, k;
    logic [31:0] p;

    reset_n    = 1'b0;
    req        = '0;
    req_period = '0;
    req_cont   = '0;
    req_irq_en = '0;
    step(3);
    check("rst ack",    64'(ack),              64'(0));
    check("rst busy",   64'(busy),             64'(0));
    check("rst owner",  64'(owner),            64'(N - 1));
    check("rst cs",     64'(av.av_chipselect), 64'(0));
    check("rst write_n",64'(av.av_write_n),    64'(1));
    check("rst addr",   64'(av.av_address),    64'(0));
    check("rst data",   64'(av.av_writedata),  64'(0));
    reset_n = 1'b1;
    step(2);
    wr_q.delete(); ack_q.delete();
    m_owner = N - 1;

    // Single request from requester 0
    req_period[31:0] = 32'h0001_2345;
    req_cont[0]      = 1'b1;
    req_irq_en[0]    = 1'b1;
    t0  = cyc;
    req = 3'b001;
    exp_seq(t0, 0, 32'h0001_2345, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      k = cyc - t0;
      check("t1 busy", 64'(busy), 64'(k >= 1 && k <= ACK_LAT));
      if (k == 1) check("t1 owner", 64'(owner), 64'(0));
      if (k == ACK_LAT) begin
        check("t1 ack", 64'(ack), 64'(3'b001));
        req[0] = 1'b0;
      end
    end
    compare("t1");

    // Two requesters held: alternation
    req_period[31:0]  = $urandom;
    req_period[63:32] = $urandom;
    req_cont   = 3'b010;
    req_irq_en = 3'b001;
    want = '{2, 2, 0};
    plan(1'b0);
    run_plan("t2");

    // Period changes after the grant are ignored
    req_period[63:32] = 32'h0000_C350;
    want = '{0, 1, 0};
    plan(1'b0);
    sch_newp[0] = 32'hFFFF_FFFF;
    run_plan("t3");

    // Zero period passes through unchanged
    req_period[95:64] = 32'h0;
    req_cont[2]   = 1'b0;
    req_irq_en[2] = 1'b1;
    want = '{0, 0, 1};
    plan(1'b0);
    run_plan("t_zero");

    // Reset in the middle of the PERIODH write, request held across it
    p = $urandom;
    req_period[31:0] = p;
    req_cont[0]   = 1'b0;
    req_irq_en[0] = 1'b1;
    t0  = cyc;
    req = 3'b001;
    while (cyc < t0 + 3 + EXTRA) step(1);
    check("t4 cs_ph",   64'(av.av_chipselect), 64'(1));
    check("t4 addr_ph", 64'(av.av_address),    64'(3));
    reset_n = 1'b0;
    step(1);
    check("t4 cs_rst",    64'(av.av_chipselect), 64'(0));
    check("t4 busy_rst",  64'(busy),             64'(0));
    check("t4 ack_rst",   64'(ack),              64'(0));
    check("t4 owner_rst", 64'(owner),            64'(N - 1));
    reset_n = 1'b1;
`ifdef TIMER_SEQ_STOP_FIRST_EN
    exp_wr_q.push_back({32'(t0 + 2), 3'd1, 16'h0008});
`endif
    exp_wr_q.push_back({32'(t0 + 2 + EXTRA), 3'd2, p[15:0]});
    exp_wr_q.push_back({32'(t0 + 3 + EXTRA), 3'd3, p[31:16]});
    m_owner = N - 1;
    s2 = cyc;
    exp_seq(s2, 0, p, 1'b0, 1'b1);
    while (cyc < s2 + ACK_LAT) step(1);
    req = '0;
    step(2);
    compare("t4");

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        want[i] = $urandom_range(0, 2);
        req_period[i*32 +: 32] = $urandom;
      end
      if (want[0] == 0 && want[1] == 0 && want[2] == 0) want[r % N] = 1;
      req_cont   = N'($urandom);
      req_irq_en = N'($urandom);
      plan(1'b1);
      run_plan("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_cfg_sequencer.md
Name: timer_cfg_sequencer

Overview:
Programs and starts the system's 16-bit-register Avalon-MM interval timer on behalf of several requesters (Nios-side config logic, PLL reconfig controller, etc.).
- Arbitrates round-robin between requesters and latches the winner's period and mode.
- Issues the fixed register write sequence to the timer slave, then acknowledges the requester.
- Sits between requester logic and the timer's s1 slave port; it is the timer's only master.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
DATA_W, 16, timer slave data width; fixed at 16.
ADDR_W, 3, timer slave address width.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
req  in  NUM_REQ  level request per requester; held until its ack
req_period  in  NUM_REQ*32  per-requester period value; requester i uses bits [32i+31:32i]
req_cont  in  NUM_REQ  per-requester continuous-mode bit
req_irq_en  in  NUM_REQ  per-requester interrupt-enable bit
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
busy  out  1  high whenever state != IDLE
owner  out  $clog2(NUM_REQ)  index of last granted requester
av_address  out  ADDR_W  timer register address
av_chipselect  out  1  timer chipselect
av_write_n  out  1  timer write strobe, active low
av_writedata  out  16  timer write data

Behaviour:
- Reset
  - Reset is synchronous, active-low, on clk.
  - State IDLE; ack=0; busy=0; owner=NUM_REQ-1, so requester 0 has first priority.
  - av_chipselect=0, av_write_n=1, av_address=0, av_writedata=0.
  - Latched period and mode cleared.
- Timer slave assumptions
  - Zero-wait-state slave; each write completes in the cycle chipselect=1 and write_n=0.
  - All av_* outputs are registered. Each write state drives exactly one cycle of cs=1, write_n=0.
- Register map
  - 0 = STATUS: any write clears the timeout flag.
  - 1 = CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 = PERIODL.
  - 3 = PERIODH.
- FSM states: IDLE, GRANT, WR_PL, WR_PH, WR_STAT, WR_CTRL, DONE. Each state lasts one cycle except IDLE.
  - IDLE: if any req bit is set, pick the first set bit searching from owner+1 (wrapping). Latch period, cont and irq_en into holding registers, update owner, go to GRANT. Otherwise stay in IDLE.
  - GRANT: no bus activity, then WR_PL. Gives one cycle for the latched data to settle.
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_STAT: addr 0, data 0. This also guarantees the CONTROL write is 2 cycles after the PERIODH write, so the timer's force_reload stop has already happened and START wins.
  - WR_CTRL: addr 1, data = 0x0004 | cont<<1 | irq_en.
  - DONE: ack[owner]=1 for one cycle, then IDLE.
- Latency: req sampled in IDLE at cycle 0 → PERIODL write at cycle 2 → ack at cycle 6. Minimum spacing between two grants is 7 cycles.
- Requests and data
  - Bus data is taken only from the holding registers. Deasserting req or changing req_period after the IDLE sample has no effect.
  - A req bit still high in the cycle after its ack is treated as a new request.
  - Simultaneous requests: round-robin order; no requester is starved beyond NUM_REQ-1 sequences.
- Boundary cases
  - period=0 is written as-is; it is the requester's responsibility.
  - reset_n low mid-sequence: next edge returns to reset state. No ack is issued, and the partial timer programming is left as-is.
- req bits at index ≥ NUM_REQ do not exist; no out-of-range handling is needed.

Optional Feature:
TIMER_SEQ_STOP_FIRST_EN
- Defined: an extra state WR_STOP is inserted between GRANT and WR_PL. It writes addr 1, data 0x0008, stopping the timer before the period is reprogrammed. Latency to ack becomes 7 cycles and spacing 8 cycles.
- Undefined: no WR_STOP state; sequence exactly as above.

Decomposition:
- Package timer_seq_pkg:
  - state enum.
  - Register address constants: TMR_ADDR_STATUS=0, TMR_ADDR_CONTROL=1, TMR_ADDR_PERIODL=2, TMR_ADDR_PERIODH=3.
  - Control bit indices: ITO=0, CONT=1, START=2, STOP=3.
- One sub-module, rr_arbiter:
  - Inputs: req, last-owner pointer.
  - Outputs: one-hot grant and encoded index.
  - Combinational; the pointer register lives in the parent.

Test Plan:
1. Reset, then req=01, period=0x0001_2345, cont=1, irq_en=1 → writes in order: (2,0x2345), (3,0x0001), (0,0x0000), (1,0x0007). ack=01 at cycle 6; busy high for cycles 1–6.
2. req=11 held continuously → grants alternate 0,1,0,1. Each ack is 7 cycles apart; owner toggles.
3. Requester 1 changes req_period from 0x0000_C350 to 0xFFFF_FFFF the cycle after grant → bus still writes 0xC350 and 0x0000.
4. reset_n=0 during WR_PH → next cycle state IDLE, av_chipselect=0, and no ack. After release, a held req restarts the full sequence.
5. With TIMER_SEQ_STOP_FIRST_EN, cont=0, irq_en=0 → (1,0x0008) write precedes PERIODL; final CONTROL data 0x0004; ack at cycle 7.
6. Connected to the real timer with period 0x0000_0009, cont=1, irq_en=1 → timer running after the sequence, irq asserts after 10 counts, and a rerun of the sequence clears it.
